// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//   Fetch stage sitting directly upstream of decode/execute. Owns the PC and
//   keeps exactly one request outstanding to instruction memory. Each returned
//   word is registered as instruction_reg = {pc, instr}; cycles without a usable
//   word carry a NOP bubble instead. A redirect from decode (update_pc/new_pc)
//   retargets the PC, and any response that belongs to the old path is dropped.
//   A misaligned redirect target latches fetch_fault and halts fetch until reset.
//
// Ports
//   i_clk            in   1   clock, all state changes on the rising edge
//   i_rstn           in   1   asynchronous active-low reset
//   imem_req         out  1   one-cycle pulse: request the word at imem_addr
//   imem_addr        out  32  request address, held until the next request
//   imem_rvalid      in   1   response valid (at least one cycle after imem_req)
//   imem_rdata       in   32  response word, sampled when imem_rvalid=1
//   update_pc        in   1   redirect from decode, acted on in the same cycle
//   new_pc           in   32  redirect target, sampled when update_pc=1
//   instruction_reg  out  64  {pc[31:0], instr[31:0]} towards decode
//   fetch_fault      out  1   sticky: misaligned redirect seen, fetch halted
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        update_pc,
  input  logic [31:0] new_pc,
  output logic [63:0] instruction_reg,
  output logic        fetch_fault
);

  // S_WAIT : the outstanding request belongs to the current path.
  // S_DRAIN: the outstanding request is stale; its response gets dropped.
  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DRAIN,
    S_HALT
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic        r_req;
  logic        w_req_next;
  logic [31:0] r_addr;
  logic [31:0] w_addr_next;
  logic [63:0] r_instr;
  logic [63:0] w_instr_next;
  logic        r_fault;
  logic        w_fault_next;

  logic        w_misaligned;
  logic [31:0] w_pc_plus4;

  assign w_misaligned = update_pc && (new_pc[1:0] != 2'b00);
  // Natural 32-bit wrap: 32'hFFFF_FFFC + 4 = 0, deliberately not a fault.
  assign w_pc_plus4   = r_pc + 32'd4;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_req   <= 1'b0;
      r_addr  <= RESET_PC;
      r_instr <= {RESET_PC, NOP_INSTR};
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_req   <= w_req_next;
      r_addr  <= w_addr_next;
      r_instr <= w_instr_next;
      r_fault <= w_fault_next;
    end
  end

  always_comb begin
    // Default: hold state, no request, emit a bubble tagged with the current pc.
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_req_next   = 1'b0;
    w_addr_next  = r_addr;
    w_instr_next = {r_pc, NOP_INSTR};
    w_fault_next = r_fault;

    if ((r_state != S_HALT) && w_misaligned) begin
      // Misaligned target: stop fetching for good; late responses are ignored
      // because S_HALT never looks at imem_rvalid.
      w_fault_next = 1'b1;
      w_state_next = S_HALT;
    end else begin
      case (r_state)
        S_IDLE: begin
          // First request after reset. Any response seen here predates it.
          w_req_next   = 1'b1;
          w_state_next = S_WAIT;
          if (update_pc) begin
            w_pc_next   = new_pc;
            w_addr_next = new_pc;
          end else begin
            w_addr_next = r_pc;
          end
        end

        S_WAIT: begin
          if (update_pc) begin
            w_pc_next = new_pc;
            if (imem_rvalid) begin
              // Old request just completed: drop its word and go straight to
              // the new target without a drain cycle.
              w_req_next  = 1'b1;
              w_addr_next = new_pc;
            end else begin
              w_state_next = S_DRAIN;
            end
          end else if (imem_rvalid) begin
            w_instr_next = {r_pc, imem_rdata};
            w_pc_next    = w_pc_plus4;
            w_req_next   = 1'b1;
            w_addr_next  = w_pc_plus4;
          end
        end

        S_DRAIN: begin
          if (update_pc) begin
            w_pc_next = new_pc;
          end
          if (imem_rvalid) begin
            // Stale word dropped; the request goes to the newest target.
            w_req_next   = 1'b1;
            w_addr_next  = update_pc ? new_pc : r_pc;
            w_state_next = S_WAIT;
          end
        end

        S_HALT: begin
          // Bubbles only, until reset.
        end

        default: begin
          w_state_next = S_HALT;
        end
      endcase
    end
  end

  assign imem_req        = r_req;
  assign imem_addr       = r_addr;
  assign instruction_reg = r_instr;
  assign fetch_fault     = r_fault;

endmodule
